// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, operand classes and sequencer states.
package fp_pkg;
  localparam int          FP_BIAS = 127;
  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_NORM, ST_DONE} state_t;

  // Denormal inputs are treated as zero.
  function automatic fp_class_t fp_classify(input logic [31:0] x);
    if (x[FRAC_W +: EXP_W] == '0) return CLS_ZERO;
    if (x[FRAC_W +: EXP_W] == '1) return (x[FRAC_W-1:0] != '0) ? CLS_NAN : CLS_INF;
    return CLS_NORM;
  endfunction
endpackage

// File: rtl/fp_round_norm.sv
// Normalise a 48b mantissa product, round to nearest-even and range-check the exponent.
module fp_round_norm
  import fp_pkg::*;
(
  input  logic [47:0]       p_i,
  input  logic signed [9:0] exp_i,
  input  logic              sign_i,
  output logic [31:0]       res_o,
  output logic              ovf_o,
  output logic              unf_o
);
  logic [22:0]       frac;
  logic [23:0]       frac_rnd;
  logic              guard, sticky, exp_inc;
  logic signed [9:0] exp_fin;

  always_comb begin
    if (p_i[47]) begin
      frac    = p_i[46:24];
      guard   = p_i[23];
      sticky  = |p_i[22:0];
      exp_inc = 1'b1;
    end else begin
      frac    = p_i[45:23];
      guard   = p_i[22];
      sticky  = |p_i[21:0];
      exp_inc = 1'b0;
    end
    // Carry out of the fraction means the mantissa rolled over to 1.0.
    frac_rnd = {1'b0, frac} + 24'(guard & (sticky | frac[0]));
    exp_fin  = exp_i + $signed({9'b0, exp_inc}) + $signed({9'b0, frac_rnd[23]});
    ovf_o    = 1'b0;
    unf_o    = 1'b0;
    res_o    = {sign_i, exp_fin[7:0], frac_rnd[22:0]};
    if (exp_fin >= 10'sd255) begin
      res_o = {sign_i, POS_INF[30:0]};
      ovf_o = 1'b1;
    end else if (exp_fin <= 10'sd0) begin
      res_o = {sign_i, 31'b0};
      unf_o = 1'b1;
    end
  end
endmodule

// File: rtl/fp_mul_seq.sv
// Iterative single-precision multiplier: shift-add mantissa product, then normalise/round.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        g_clk,
  input  logic        n_reset,
  input  logic        start_i,
  input  logic [31:0] multiplicand_i,
  input  logic [31:0] multiplier_i,
  output logic [31:0] product_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        invalid_o
);
  localparam int N  = 24 / RADIX_BITS;
  localparam int CW = $clog2(N);

  state_t            state_q;
  fp_class_t         cls_a_q, cls_b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [47:0]       ma_q, acc_q, acc_d;
  logic [23:0]       mb_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       res_q, rn_res;
  logic              ovf_q, unf_q, inv_q, rn_ovf, rn_unf;

  // Retire RADIX_BITS multiplier bits per cycle against the pre-shifted multiplicand.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < RADIX_BITS; j++)
      if (mb_q[j]) acc_d = acc_d + (ma_q << j);
  end

  fp_round_norm u_rn (
    .p_i   (acc_q),
    .exp_i (exp_q),
    .sign_i(sign_q),
    .res_o (rn_res),
    .ovf_o (rn_ovf),
    .unf_o (rn_unf)
  );

  always_ff @(posedge g_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      cls_a_q     <= CLS_ZERO;
      cls_b_q     <= CLS_ZERO;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
      product_o   <= '0;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      invalid_o   <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (start_i) begin
          cls_a_q <= fp_classify(multiplicand_i);
          cls_b_q <= fp_classify(multiplier_i);
          sign_q  <= multiplicand_i[31] ^ multiplier_i[31];
          exp_q   <= $signed({2'b00, multiplicand_i[30:23]}) + $signed({2'b00, multiplier_i[30:23]})
                     - 10'(FP_BIAS);
          ma_q    <= {24'b0, 1'b1, multiplicand_i[22:0]};
          mb_q    <= {1'b1, multiplier_i[22:0]};
          acc_q   <= '0;
          cnt_q   <= CW'(N - 1);
          busy_o  <= 1'b1;
          state_q <= ST_MUL;
        end
        ST_MUL: begin
          acc_q <= acc_d;
          ma_q  <= ma_q << RADIX_BITS;
          mb_q  <= mb_q >> RADIX_BITS;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= ST_NORM;
        end
        ST_NORM: begin
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
          inv_q <= 1'b0;
          if (cls_a_q == CLS_NAN || cls_b_q == CLS_NAN ||
              (cls_a_q == CLS_ZERO && cls_b_q == CLS_INF) ||
              (cls_a_q == CLS_INF && cls_b_q == CLS_ZERO)) begin
            res_q <= QNAN;
            inv_q <= 1'b1;
          end else if (cls_a_q == CLS_INF || cls_b_q == CLS_INF) begin
            res_q <= {sign_q, POS_INF[30:0]};
          end else if (cls_a_q == CLS_ZERO || cls_b_q == CLS_ZERO) begin
            res_q <= {sign_q, 31'b0};
          end else begin
            res_q <= rn_res;
            ovf_q <= rn_ovf;
            unf_q <= rn_unf;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          product_o   <= res_q;
          overflow_o  <= ovf_q;
          underflow_o <= unf_q;
          invalid_o   <= inv_q;
          ready_o     <= 1'b1;
          busy_o      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: three radix variants driven in lockstep against an arithmetic reference.
module tb_fp_mul_seq;
  localparam int NDUT = 3;
  localparam int RADIX [NDUT] = '{1, 4, 8};

  logic        g_clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] prod [NDUT];
  logic        rdy [NDUT], bsy [NDUT], ovf [NDUT], unf [NDUT], inv [NDUT];

  int          n_chk = 0, n_fail = 0;
  logic [31:0] got_p [NDUT];
  logic [2:0]  got_f [NDUT];
  int          got_lat [NDUT], pulses [NDUT];

  always #5 g_clk = ~g_clk;

  fp_mul_seq #(.RADIX_BITS(RADIX[0])) u_r1 (
    .g_clk(g_clk), .n_reset(n_reset), .start_i(start), .multiplicand_i(a), .multiplier_i(b),
    .product_o(prod[0]), .ready_o(rdy[0]), .busy_o(bsy[0]),
    .overflow_o(ovf[0]), .underflow_o(unf[0]), .invalid_o(inv[0]));
  fp_mul_seq #(.RADIX_BITS(RADIX[1])) u_r4 (
    .g_clk(g_clk), .n_reset(n_reset), .start_i(start), .multiplicand_i(a), .multiplier_i(b),
    .product_o(prod[1]), .ready_o(rdy[1]), .busy_o(bsy[1]),
    .overflow_o(ovf[1]), .underflow_o(unf[1]), .invalid_o(inv[1]));
  fp_mul_seq #(.RADIX_BITS(RADIX[2])) u_r8 (
    .g_clk(g_clk), .n_reset(n_reset), .start_i(start), .multiplicand_i(a), .multiplier_i(b),
    .product_o(prod[2]), .ready_o(rdy[2]), .busy_o(bsy[2]),
    .overflow_o(ovf[2]), .underflow_o(unf[2]), .invalid_o(inv[2]));

  function automatic int lat_of(input int k);
    return 24 / RADIX[k] + 2;
  endfunction

  // Reference: exact integer product, rounded by remainder comparison. Returns {inv,unf,ovf,result}.
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ea, eb, e, s;
    logic sg, za, zb, ia, ib, na, nb;
    logic [63:0] p, q, rem, half;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    sg = x[31] ^ y[31];
    za = (ea == 0); zb = (eb == 0);
    na = (ea == 255) && (x[22:0] != 0); nb = (eb == 255) && (y[22:0] != 0);
    ia = (ea == 255) && !na;            ib = (eb == 255) && !nb;
    if (na || nb || (za && ib) || (ia && zb)) return {3'b100, 32'h7FC00000};
    if (ia || ib) return {3'b000, sg, 8'hFF, 23'h0};
    if (za || zb) return {3'b000, sg, 31'h0};
    p = {40'h0, 1'b1, x[22:0]} * {40'h0, 1'b1, y[22:0]};
    s = (p >= 64'h8000_0000_0000) ? 24 : 23;
    q = p >> s;
    rem = p - (q << s);
    half = 64'd1 << (s - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = ea + eb - 127 + (s - 23);
    if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return {3'b001, sg, 8'hFF, 23'h0};
    if (e <= 0) return {3'b010, sg, 31'h0};
    return {3'b000, sg, e[7:0], q[22:0]};
  endfunction

  // Start one operation (start held through edge 'hold'), then watch 40 cycles.
  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input int hold);
    for (int k = 0; k < NDUT; k++) begin pulses[k] = 0; got_lat[k] = -1; got_p[k] = '0; got_f[k] = '0; end
    @(negedge g_clk); a = ai; b = bi; start = 1'b1;
    @(posedge g_clk); #1;
    if (hold == 0) start = 1'b0;
    a = $urandom; b = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(posedge g_clk); #1;
      if (c >= hold) start = 1'b0;
      for (int k = 0; k < NDUT; k++)
        if (rdy[k]) begin
          pulses[k]++; got_lat[k] = c; got_p[k] = prod[k]; got_f[k] = {inv[k], unf[k], ovf[k]};
        end
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    #12;
    for (int k = 0; k < NDUT; k++) begin
      n_chk++;
      if ({prod[k], rdy[k], bsy[k], ovf[k], unf[k], inv[k]} !== 37'b0) begin
        n_fail++;
        $display("FAIL reset_state r%0d: got prod=%h rdy=%b busy=%b flags=%b%b%b, want all zero",
                 RADIX[k], prod[k], rdy[k], bsy[k], inv[k], unf[k], ovf[k]);
      end
    end
    @(negedge g_clk); n_reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [11], tb [11], tp [11];
    logic [2:0]  tf [11];
    ta = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F000000, 32'h00800000,
           32'h00000000, 32'h7FC00001, 32'h7F800000, 32'h80000000, 32'h3FFFFFFF};
    tb = '{32'h40400000, 32'h3FC00000, 32'h40400000, 32'h3F800001, 32'h40000000, 32'h3F000000,
           32'h7F800000, 32'h3F800000, 32'hC0000000, 32'h40000000, 32'h3FFFFFFF};
    tp = '{32'h40C00000, 32'h40100000, 32'hC0C00000, 32'h3F800002, 32'h7F800000, 32'h00000000,
           32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h407FFFFE};
    tf = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 11; i++) begin
      run_op(ta[i], tb[i], 0);
      for (int k = 0; k < NDUT; k++) begin
        n_chk++;
        if (got_p[k] !== tp[i]) begin
          n_fail++; $display("FAIL dir%0d_product r%0d: got %h want %h", i, RADIX[k], got_p[k], tp[i]);
        end
        n_chk++;
        if (got_f[k] !== tf[i]) begin
          n_fail++; $display("FAIL dir%0d_flags r%0d: got %b want %b", i, RADIX[k], got_f[k], tf[i]);
        end
        n_chk++;
        if (got_lat[k] != lat_of(k) || pulses[k] != 1) begin
          n_fail++; $display("FAIL dir%0d_latency r%0d: got lat=%0d pulses=%0d want lat=%0d pulses=1",
                             i, RADIX[k], got_lat[k], pulses[k], lat_of(k));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic [34:0] exp_r;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 4 != 0) begin
        ra[30:23] = 8'($urandom_range(64, 190));
        rb[30:23] = 8'($urandom_range(64, 190));
      end
      if (i % 8 == 4) ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      exp_r = ref_mul(ra, rb);
      run_op(ra, rb, 0);
      for (int k = 0; k < NDUT; k++) begin
        n_chk++;
        if (got_p[k] !== exp_r[31:0] || got_f[k] !== exp_r[34:32] || got_lat[k] != lat_of(k) || pulses[k] != 1) begin
          n_fail++;
          $display("FAIL rand%0d r%0d (%h x %h): got %h flags=%b lat=%0d pulses=%0d want %h flags=%b lat=%0d",
                   i, RADIX[k], ra, rb, got_p[k], got_f[k], got_lat[k], pulses[k],
                   exp_r[31:0], exp_r[34:32], lat_of(k));
        end
      end
    end
  endtask

  task automatic test_start_held();
    run_op(32'h40000000, 32'h40400000, 5);
    for (int k = 0; k < NDUT; k++) begin
      n_chk++;
      if (pulses[k] != 1 || got_lat[k] != lat_of(k) || got_p[k] !== 32'h40C00000) begin
        n_fail++;
        $display("FAIL start_held r%0d: got pulses=%0d lat=%0d prod=%h want pulses=1 lat=%0d prod=40c00000",
                 RADIX[k], pulses[k], got_lat[k], got_p[k], lat_of(k));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int late;
    @(negedge g_clk); a = 32'h3FC00000; b = 32'h40400000; start = 1'b1;
    @(posedge g_clk); #1; start = 1'b0;
    @(posedge g_clk); @(posedge g_clk); #1;
    n_reset = 1'b0;
    #2;
    for (int k = 0; k < NDUT; k++) begin
      n_chk++;
      if (prod[k] !== 32'h0 || bsy[k] !== 1'b0 || rdy[k] !== 1'b0) begin
        n_fail++; $display("FAIL midreset_state r%0d: got prod=%h busy=%b rdy=%b want 0/0/0",
                           RADIX[k], prod[k], bsy[k], rdy[k]);
      end
    end
    @(negedge g_clk); @(negedge g_clk); n_reset = 1'b1;
    late = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge g_clk); #1;
      for (int k = 0; k < NDUT; k++) if (rdy[k]) late++;
    end
    n_chk++;
    if (late != 0) begin
      n_fail++; $display("FAIL midreset_no_ready: got %0d ready pulses want 0", late);
    end
    run_op(32'h3FC00000, 32'h40400000, 0);
    for (int k = 0; k < NDUT; k++) begin
      n_chk++;
      if (got_p[k] !== 32'h40900000 || got_f[k] !== 3'b000 || got_lat[k] != lat_of(k) || pulses[k] != 1) begin
        n_fail++;
        $display("FAIL midreset_recover r%0d: got %h flags=%b lat=%0d pulses=%0d want 40900000 flags=000 lat=%0d",
                 RADIX[k], got_p[k], got_f[k], got_lat[k], pulses[k], lat_of(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
